serial_port_ctrl: RTL and testbench

- Controller between the processor's byte-wide serial port and an external UART byte interface.
- Buffers outbound bytes in a small TX FIFO and paces them to the UART with a programmable inter-byte gap.
- Holds one inbound byte for the processor and flags drops as sticky errors.
- Instantiated beside `processor`: it drives `serial_ready_in` and `serial_valid_in`, and consumes `serial_wren_out` and `serial_rden_out`.

---
 rtl/serial_port_ctrl_pkg.sv | 21 ++
 rtl/serial_port_ctrl_if.sv | 39 +++
 rtl/serial_port_ctrl_tx_fifo.sv | 76 +++++++
 rtl/serial_port_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_port_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_port_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_ctrl_defs : shared state encodings and default sizing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_ctrl_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_e;

   localparam int unsigned DEF_TX_DEPTH = 4;
   localparam int unsigned DEF_TX_GAP   = 2;
   localparam int unsigned DEF_GAP_W    = 8;

endpackage

`default_nettype wire

// File: rtl/serial_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_port_ctrl_if : processor / UART byte handshakes and error flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_port_ctrl_if;

   logic [7:0] proc_wdata;
   logic       proc_wren;
   logic       proc_ready;
   logic       proc_rden;
   logic [7:0] proc_rdata;
   logic       proc_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       tx_overflow;
   logic       rx_overflow;
   logic       clear_err;

   modport master (
      output proc_wdata, proc_wren, proc_rden, tx_ready, rx_data, rx_valid, clear_err,
      input  proc_ready, proc_rdata, proc_valid, tx_data, tx_valid, rx_ready,
             tx_overflow, rx_overflow
   );

   modport slave (
      input  proc_wdata, proc_wren, proc_rden, tx_ready, rx_data, rx_valid, clear_err,
      output proc_ready, proc_rdata, proc_valid, tx_data, tx_valid, rx_ready,
             tx_overflow, rx_overflow
   );

endinterface

`default_nettype wire

// File: rtl/serial_port_ctrl_tx_fifo.sv
// ---------------------------------------------------------------------------
// serial_tx_fifo : outbound byte FIFO, power-of-two depth, head exposed on dout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_tx_fifo #(
   parameter int unsigned TX_DEPTH = 4
) (
   input  wire logic                        clock,
   input  wire logic                        reset,
   input  wire logic                        push,
   input  wire logic                        pop,
   input  wire logic [7:0]                  din,
   output      logic [7:0]                  dout,
   output      logic [$clog2(TX_DEPTH):0]   count,
   output      logic                        full,
   output      logic                        empty
);

   localparam int unsigned PTR_W = $clog2(TX_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [7:0]       mem_q [TX_DEPTH];
   logic [7:0]       mem_d [TX_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(TX_DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TX_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/serial_port_ctrl.sv
// ---------------------------------------------------------------------------
// serial_port_ctrl : paced TX FIFO to the UART, single-byte RX hold, sticky drops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_port_ctrl
   import serial_ctrl_defs::*;
#(
   parameter int unsigned TX_DEPTH = DEF_TX_DEPTH,
   parameter int unsigned TX_GAP   = DEF_TX_GAP,
   parameter int unsigned GAP_W    = DEF_GAP_W
) (
   input wire logic           clock,
   input wire logic           reset,
   serial_port_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(TX_DEPTH) + 1;

   tx_state_e        state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             rx_full_q, rx_full_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             tx_ovf_q, tx_ovf_d;
   logic             rx_ovf_q, rx_ovf_d;

   logic [7:0]       fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
   logic             push, pop, tx_valid;

   assign push     = bus.proc_wren && !fifo_full;
   assign tx_valid = (state_q == ST_SEND);
   assign pop      = tx_valid && bus.tx_ready;

   serial_tx_fifo #(
      .TX_DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus.proc_wdata),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The FIFO head is frozen while SEND waits, so it doubles as tx_data.
   // Leaving GAP straight into SEND keeps the idle time at exactly TX_GAP.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (bus.tx_ready) begin
               if (TX_GAP > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_W'(TX_GAP - 1);
               end else if ((fifo_count > CNT_W'(1)) || push) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = fifo_empty ? ST_IDLE : ST_SEND;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_full_d = rx_full_q;
      rx_byte_d = rx_byte_q;
      if (bus.rx_valid && !rx_full_q) begin
         rx_full_d = 1'b1;
         rx_byte_d = bus.rx_data;
      end else if (bus.proc_rden && rx_full_q) begin
         rx_full_d = 1'b0;
      end
      // A new drop on the clearing edge keeps the flag set.
      tx_ovf_d = (bus.proc_wren && fifo_full) ? 1'b1 : (bus.clear_err ? 1'b0 : tx_ovf_q);
      rx_ovf_d = (bus.rx_valid && rx_full_q)  ? 1'b1 : (bus.clear_err ? 1'b0 : rx_ovf_q);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         gap_q     <= '0;
         rx_full_q <= 1'b0;
         rx_byte_q <= '0;
         tx_ovf_q  <= 1'b0;
         rx_ovf_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         rx_full_q <= rx_full_d;
         rx_byte_q <= rx_byte_d;
         tx_ovf_q  <= tx_ovf_d;
         rx_ovf_q  <= rx_ovf_d;
      end
   end

   assign bus.proc_ready  = reset && !fifo_full;
   assign bus.tx_valid    = tx_valid;
   assign bus.tx_data     = tx_valid ? fifo_dout : 8'h00;
   assign bus.rx_ready    = reset && !rx_full_q;
   assign bus.proc_valid  = rx_full_q;
   assign bus.proc_rdata  = rx_byte_q;
   assign bus.tx_overflow = tx_ovf_q;
   assign bus.rx_overflow = rx_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_port_ctrl : scoreboard bench for serial_port_ctrl (TX_DEPTH=4, TX_GAP=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_port_ctrl;

   localparam int TX_DEPTH = 4;
   localparam int TX_GAP   = 2;

   logic clock;
   logic reset_n;

   serial_port_ctrl_if bus ();

   serial_port_ctrl #(
      .TX_DEPTH (TX_DEPTH),
      .TX_GAP   (TX_GAP),
      .GAP_W    (8)
   ) dut (
      .clock (clock),
      .reset (reset_n),
      .bus   (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] q[$];
   logic       exp_txov, exp_rxov, exp_full;
   logic [7:0] exp_byte;
   int         low_cnt;
   logic       have_prev;
   logic       gap_chk;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Outputs are checked against the model state left by the previous edge,
   // then the model is advanced with the inputs that the next edge will see.
   always @(negedge clock) begin
      int   pre;
      logic old_full;
      if (!reset_n) begin
         chk("rst_proc_ready", bus.proc_ready, 0);
         chk("rst_tx_valid", bus.tx_valid, 0);
         chk("rst_tx_data", bus.tx_data, 0);
         chk("rst_rx_ready", bus.rx_ready, 0);
         chk("rst_proc_valid", bus.proc_valid, 0);
         chk("rst_proc_rdata", bus.proc_rdata, 0);
         chk("rst_tx_ovf", bus.tx_overflow, 0);
         chk("rst_rx_ovf", bus.rx_overflow, 0);
         q.delete();
         exp_txov  = 1'b0;
         exp_rxov  = 1'b0;
         exp_full  = 1'b0;
         exp_byte  = 8'h00;
         low_cnt   = 0;
         have_prev = 1'b0;
      end else begin
         chk("proc_ready", bus.proc_ready, (q.size() < TX_DEPTH));
         chk("tx_overflow", bus.tx_overflow, exp_txov);
         chk("rx_overflow", bus.rx_overflow, exp_rxov);
         chk("proc_valid", bus.proc_valid, exp_full);
         chk("rx_ready", bus.rx_ready, !exp_full);
         chk("proc_rdata", bus.proc_rdata, exp_byte);
         if (bus.tx_valid) begin
            chk("tx_has_expected", (q.size() != 0), 1);
            if (q.size() != 0) chk("tx_data", bus.tx_data, q[0]);
         end else begin
            low_cnt++;
         end

         pre = q.size();
         if (bus.tx_valid && bus.tx_ready && pre > 0) begin
            if (gap_chk && have_prev) chk("gap_cycles", low_cnt, TX_GAP);
            have_prev = gap_chk;
            low_cnt   = 0;
            void'(q.pop_front());
         end
         if (bus.proc_wren && pre < TX_DEPTH) q.push_back(bus.proc_wdata);
         if (bus.proc_wren && pre >= TX_DEPTH) exp_txov = 1'b1;
         else if (bus.clear_err) exp_txov = 1'b0;

         old_full = exp_full;
         if (bus.rx_valid && !old_full) begin
            exp_full = 1'b1;
            exp_byte = bus.rx_data;
         end else if (bus.proc_rden && old_full) begin
            exp_full = 1'b0;
         end
         if (bus.rx_valid && old_full) exp_rxov = 1'b1;
         else if (bus.clear_err) exp_rxov = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      bus.proc_wdata = b;
      bus.proc_wren  = 1'b1;
      tick();
      bus.proc_wren  = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q.size() != 0 || bus.tx_valid) && n < 200) begin
         tick();
         n++;
      end
      chk("drain_in_time", (n < 200), 1);
   endtask

   task automatic wait_tx_valid();
      int n = 0;
      while (!bus.tx_valid && n < 20) begin
         tick();
         n++;
      end
      chk("tx_valid_in_time", (n < 20), 1);
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.proc_wdata = 8'h00;
      bus.proc_wren  = 1'b0;
      bus.proc_rden  = 1'b0;
      bus.tx_ready   = 1'b0;
      bus.rx_data    = 8'h00;
      bus.rx_valid   = 1'b0;
      bus.clear_err  = 1'b0;
      gap_chk        = 1'b0;

      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      tick();
      chk("ready_after_reset", bus.proc_ready, 1);
      chk("idle_tx_valid", bus.tx_valid, 0);

      // Single byte latency with the UART always ready.
      bus.tx_ready = 1'b1;
      write_byte(8'h41);
      chk("lat_edge_k", bus.tx_valid, 0);
      tick();
      chk("lat_edge_k1_valid", bus.tx_valid, 1);
      chk("lat_edge_k1_data", bus.tx_data, 8'h41);
      tick();
      chk("single_one_cycle", bus.tx_valid, 0);
      repeat (4) tick();

      // Burst fills the FIFO, fifth write is dropped, then paced drain.
      bus.tx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) write_byte(i[7:0]);
      chk("burst_full_ready", bus.proc_ready, 0);
      write_byte(8'h05);
      chk("burst_overflow", bus.tx_overflow, 1);
      gap_chk      = 1'b1;
      bus.tx_ready = 1'b1;
      wait_drain();
      gap_chk = 1'b0;
      repeat (3) tick();
      bus.clear_err = 1'b1;
      tick();
      bus.clear_err = 1'b0;
      chk("clear_after_burst", bus.tx_overflow, 0);

      // RX holding register.
      rx_byte(8'h5A);
      chk("rx_hold_valid", bus.proc_valid, 1);
      chk("rx_hold_data", bus.proc_rdata, 8'h5A);
      chk("rx_hold_ready", bus.rx_ready, 0);
      rx_byte(8'hA5);
      chk("rx_drop_ovf", bus.rx_overflow, 1);
      chk("rx_drop_keeps", bus.proc_rdata, 8'h5A);
      bus.proc_rden = 1'b1;
      tick();
      bus.proc_rden = 1'b0;
      chk("rx_read_valid", bus.proc_valid, 0);
      chk("rx_read_ready", bus.rx_ready, 1);

      // Push while full on the same edge as a pop: push is dropped.
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_byte(8'h10 + i[7:0]);
      wait_tx_valid();
      chk("pp_full", bus.proc_ready, 0);
      bus.tx_ready   = 1'b1;
      bus.proc_wdata = 8'hEE;
      bus.proc_wren  = 1'b1;
      tick();
      bus.proc_wren  = 1'b0;
      bus.tx_ready   = 1'b0;
      chk("pp_overflow", bus.tx_overflow, 1);
      chk("pp_count3_ready", bus.proc_ready, 1);
      bus.tx_ready = 1'b1;
      wait_drain();
      repeat (3) tick();

      // Asynchronous reset in the middle of a handshake.
      bus.tx_ready = 1'b0;
      write_byte(8'h77);
      wait_tx_valid();
      reset_n = 1'b0;
      #1;
      chk("async_rst_tx_valid", bus.tx_valid, 0);
      chk("async_rst_ready", bus.proc_ready, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      bus.tx_ready = 1'b1;
      tick();
      chk("post_rst_ready", bus.proc_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_no_tx", bus.tx_valid, 0);
      end

      // Sticky flags: set wins over clear on the same edge, then clear.
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_byte(8'h20 + i[7:0]);
      rx_byte(8'h33);
      bus.proc_wdata = 8'h99;
      bus.proc_wren  = 1'b1;
      bus.rx_data    = 8'h44;
      bus.rx_valid   = 1'b1;
      bus.clear_err  = 1'b1;
      tick();
      bus.proc_wren  = 1'b0;
      bus.rx_valid   = 1'b0;
      bus.clear_err  = 1'b0;
      chk("set_wins_tx", bus.tx_overflow, 1);
      chk("set_wins_rx", bus.rx_overflow, 1);
      bus.clear_err = 1'b1;
      tick();
      bus.clear_err = 1'b0;
      chk("clear_tx_ovf", bus.tx_overflow, 0);
      chk("clear_rx_ovf", bus.rx_overflow, 0);
      chk("clear_keeps_rx", bus.proc_rdata, 8'h33);

      bus.tx_ready = 1'b1;
      wait_drain();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
